instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder-side counterpart of decoder_controller: takes field-level instruction requests (class, rd, rs1, rs2,
//  funct3, funct7, imm), packs them into RV32I instruction words and writes them to instruction memory.
//  Used as the program preloader / self-test stimulus source ahead of the single-cycle core.
//  Valid/ready input, small FIFO, sequential IMEM write port driven by a word-address counter.
// PARAMETERS
//  ADDR_W      8   IMEM word-address width; capacity = 2**ADDR_W words
//  FIFO_DEPTH  4   encoded-word buffer depth (power of 2, >=2)
//  BASE_ADDR   0   first IMEM word address written after start
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse: begin a load session (ignored while busy)
//  in_valid    in   1       request valid
//  in_ready    out  1       request accepted when in_valid & in_ready
//  in_class    in   4       0 OP,1 OP_IMM,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC; 9-15 illegal
//  in_rd/in_rs1/in_rs2 in 5 each  register indices
//  in_funct3   in   3       funct3 (forced 000 for JALR; unused for JAL/LUI/AUIPC)
//  in_funct7   in   7       funct7 (OP, and OP_IMM shifts f3=001/101 into bits[31:25])
//  in_imm      in   32      byte immediate; U-type uses in_imm[31:12]; B/J bit0 dropped
//  in_last     in   1       marks final request of the session
//  imem_we     out  1       IMEM write strobe
//  imem_addr   out  ADDR_W  IMEM word address
//  imem_wdata  out  32      encoded instruction
//  busy        out  1       session in progress
//  done        out  1       high from session end until next accepted start
//  full        out  1       session ended by IMEM capacity, not in_last
//  count       out  ADDR_W+1 words written this session
//  err         out  1       (ENC_CHECK_EN only) sticky illegal-request flag
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; address=BASE_ADDR.
//  FSM IDLE -start-> LOAD -(last accepted & FIFO drained) or capacity-> DONE -start-> LOAD. start in LOAD ignored.
//  start in IDLE/DONE: clears done/full/count/err, addr=BASE_ADDR, next cycle in_ready may assert.
//  in_ready = LOAD & !fifo_full & !last_seen & (count+fifo_occ < 2**ADDR_W).
//  Accept: word encoded combinationally, pushed to FIFO same edge. Drain: FIFO non-empty -> imem_we=1 next cycle
//   with head word; addr,count +1 per write. Min latency accept->imem_we = 1 cycle; push+pop same cycle allowed.
//  Formats: R/I/S/B/U/J per RV32I; OP 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011,
//   JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Immediates truncated, never saturated.
//  Illegal class: encodes canonical NOP 0x00000013 (addi x0,x0,0).
//  Capacity: after 2**ADDR_W writes -> DONE with full=1; addr wraps to BASE_ADDR but no further write issued.
//  done asserts the cycle after the final imem_we. Reset mid-session aborts immediately; FIFO contents lost.
// CONFIGURATION
//  ENC_CHECK_EN defined: err sets on illegal class, or imm not representable in its format (sign-extension
//   mismatch, or B/J imm[0]=1); word still written (NOP for illegal class). Undefined: err tied 0, no checks.
// STRUCTURE
//  riscv_pkg: opcode constants (shared with decoder_controller), class codes, NOP constant, format enum.
//  Sub-module instr_field_packer: combinational class+fields -> 32-bit word; FSM, FIFO, counter in top.
// TESTING
//  1 start; add x1,x2,x3 (last) -> one imem_we, addr 0, wdata 0x003100B3, then done=1, count=1.
//  2 addi x1,x0,5; lw x5,8(x2); sw x5,12(x2); beq x1,x2,+8; jal x1,+16; lui x1,0x12345 back-to-back ->
//    0x00500093,0x00812283,0x00512623,0x00208463,0x010000EF,0x123450B7 at addr 0..5.
//  3 in_valid held, ADDR_W=2 -> exactly 4 writes, in_ready low after, full=1, done=1.
//  4 illegal class 12 -> wdata 0x00000013; err=1 only with ENC_CHECK_EN; beq imm=3 sets err likewise.
//  5 rst_n low mid-session with FIFO non-empty -> all outputs 0 asynchronously, no further imem_we.
//  6 start during LOAD ignored; start in DONE restarts at BASE_ADDR with count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I encoding constants for the instruction encoder/loader and the
// decoder controller: major opcodes, request class codes, the canonical NOP,
// an instruction format enum and the loader FSM state enum.
// Helper functions:
//   class_format : request class -> instruction format (FMT_BAD for 9..15)
//   class_legal  : 1 when the class code names a real instruction class
//   imm_fits     : 1 when the byte immediate survives packing unchanged
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Major opcodes, bits [6:0] of every RV32I word
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Request class codes carried on in_class
    localparam logic [3:0] CLS_OP     = 4'd0;
    localparam logic [3:0] CLS_OP_IMM = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;

    // addi x0,x0,0 -- written in place of any illegal request
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } load_state_e;

    function automatic fmt_e class_format(input logic [3:0] cls);
        fmt_e fmt;
        case (cls)
            CLS_OP:                       fmt = FMT_R;
            CLS_OP_IMM, CLS_LOAD, CLS_JALR: fmt = FMT_I;
            CLS_STORE:                    fmt = FMT_S;
            CLS_BRANCH:                   fmt = FMT_B;
            CLS_JAL:                      fmt = FMT_J;
            CLS_LUI, CLS_AUIPC:           fmt = FMT_U;
            default:                      fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

    function automatic logic class_legal(input logic [3:0] cls);
        return (cls <= CLS_AUIPC);
    endfunction

    // Shift-immediates are unsigned 5-bit amounts; every other immediate must
    // be the sign extension of its encoded field, and branch/jump targets must
    // be even because bit 0 is not encoded.
    function automatic logic imm_fits(input logic [3:0]  cls,
                                      input logic [2:0]  f3,
                                      input logic [31:0] imm);
        logic ok;
        ok = 1'b1;
        case (class_format(cls))
            FMT_I: begin
                if ((cls == CLS_OP_IMM) && (f3[1:0] == 2'b01)) begin
                    ok = (imm[31:5] == 27'd0);
                end else begin
                    ok = (imm[31:11] == {21{imm[11]}});
                end
            end
            FMT_S: ok = (imm[31:11] == {21{imm[11]}});
            FMT_B: ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            FMT_J: ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// ---------------------------------------------------------------------------
// instr_field_packer
// Purely combinational: packs one field-level request into a 32-bit RV32I
// instruction word. Illegal classes produce the canonical NOP. Immediates
// are truncated to their field, never saturated.
// Ports:
//   class_i  [3:0]  request class (riscv_pkg CLS_*)
//   rd_i, rs1_i, rs2_i [4:0]  register indices
//   funct3_i [2:0]  funct3 (ignored for JALR, which always uses 000)
//   funct7_i [6:0]  funct7 for OP and OP_IMM shifts
//   imm_i    [31:0] byte immediate
//   word_o   [31:0] encoded instruction
// ---------------------------------------------------------------------------
module instr_field_packer
    import riscv_pkg::*;
(
    input  logic [3:0]  class_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o
);

    fmt_e       fmt;
    logic [6:0] opcode;
    logic [2:0] funct3Eff;
    logic       isShift;

    assign fmt       = class_format(class_i);
    // slli/srli/srai carry funct7 in the upper bits instead of imm[11:5]
    assign isShift   = (class_i == CLS_OP_IMM) && (funct3_i[1:0] == 2'b01);
    assign funct3Eff = (class_i == CLS_JALR) ? 3'b000 : funct3_i;

    // Map the request class onto its major opcode
    always_comb begin
        opcode = OPC_OP_IMM;
        case (class_i)
            CLS_OP:     opcode = OPC_OP;
            CLS_OP_IMM: opcode = OPC_OP_IMM;
            CLS_LOAD:   opcode = OPC_LOAD;
            CLS_STORE:  opcode = OPC_STORE;
            CLS_BRANCH: opcode = OPC_BRANCH;
            CLS_JAL:    opcode = OPC_JAL;
            CLS_JALR:   opcode = OPC_JALR;
            CLS_LUI:    opcode = OPC_LUI;
            CLS_AUIPC:  opcode = OPC_AUIPC;
            default:    opcode = OPC_OP_IMM;
        endcase
    end

    // Scatter the fields into the bit layout of the selected format
    always_comb begin
        word_o = NOP_WORD;
        case (fmt)
            FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3Eff, rd_i, opcode};
            FMT_I: begin
                if (isShift) begin
                    word_o = {funct7_i, imm_i[4:0], rs1_i, funct3Eff, rd_i, opcode};
                end else begin
                    word_o = {imm_i[11:0], rs1_i, funct3Eff, rd_i, opcode};
                end
            end
            FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3Eff, imm_i[4:0], opcode};
            FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3Eff,
                             imm_i[4:1], imm_i[11], opcode};
            FMT_U: word_o = {imm_i[31:12], rd_i, opcode};
            FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode};
            default: word_o = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
// Program preloader: accepts field-level instruction requests over a
// valid/ready handshake, encodes them to RV32I words, buffers them in a small
// FIFO and writes them to sequential IMEM word addresses starting at
// BASE_ADDR. A session starts on a start pulse and ends when the request
// flagged in_last has been written, or when the IMEM is full.
// Optional feature macro: ENC_CHECK_EN -- when defined, err becomes a sticky
// flag for illegal classes and unrepresentable immediates; otherwise err=0.
// Parameters: ADDR_W (IMEM word-address width), FIFO_DEPTH (power of 2, >=2),
//             BASE_ADDR (first word address of a session).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a session (ignored while busy)
//   in_valid/in_ready          request handshake
//   in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last
//                              request fields
//   imem_we/imem_addr/imem_wdata  IMEM write port
//   busy, done, full, count, err  session status
// ---------------------------------------------------------------------------
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CAP_W = ADDR_W + 2;

    localparam logic [CAP_W-1:0]  CAPACITY  = {1'b0, 1'b1, {ADDR_W{1'b0}}};
    localparam logic [CAP_W-1:0]  CAP_ONE   = CAP_W'(1);
    localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              lastSeen_q, lastSeen_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [31:0]       fifoMem_q [FIFO_DEPTH];

    logic [31:0]       encWord;
    logic              inLoad;
    logic              fifoEmpty;
    logic              fifoFull;
    logic              push;
    logic              pop;
    logic              startOk;
    logic              capacityHit;
    logic              drained;
    logic [CAP_W-1:0]  loadLevel;
    logic [OCC_W-1:0]  occNext;

    instr_field_packer u_packer (
        .class_i  (in_class),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .imm_i    (in_imm),
        .word_o   (encWord)
    );

    assign inLoad    = (state_q == ST_LOAD);
    assign fifoEmpty = (occ_q == '0);
    assign fifoFull  = (occ_q == OCC_FULL);
    assign pop       = inLoad && !fifoEmpty;
    // Words already written plus words still buffered must never exceed the
    // IMEM, so acceptance stops once that total reaches capacity.
    assign loadLevel = CAP_W'(count_q) + CAP_W'(occ_q);
    assign in_ready  = inLoad && !fifoFull && !lastSeen_q && (loadLevel < CAPACITY);
    assign push      = in_valid && in_ready;
    assign startOk   = start && !inLoad;
    assign occNext   = occ_q + (push ? OCC_ONE : '0) - (pop ? OCC_ONE : '0);
    assign capacityHit = pop && ((CAP_W'(count_q) + CAP_ONE) == CAPACITY);
    assign drained     = lastSeen_q && (occNext == '0);

    // Session FSM: LOAD runs until the last request has left the FIFO or the
    // IMEM has been filled; start only has an effect outside LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: if (capacityHit || drained) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: a start re-arms the session counters; while loading,
    // every pop writes the head word and advances address and count.
    always_comb begin
        addr_d     = addr_q;
        count_d    = count_q;
        full_d     = full_q;
        lastSeen_d = lastSeen_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        occ_d      = occ_q;
        if (startOk) begin
            addr_d     = ADDR_BASE;
            count_d    = '0;
            full_d     = 1'b0;
            lastSeen_d = 1'b0;
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            occ_d      = '0;
        end else if (inLoad) begin
            if (pop) begin
                addr_d  = addr_q + ADDR_ONE;
                count_d = count_q + CNT_ONE;
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (push) begin
                wrPtr_d    = wrPtr_q + PTR_ONE;
                lastSeen_d = lastSeen_q | in_last;
            end
            occ_d = occNext;
            // A session whose final word was the in_last request ended
            // normally even if that word happened to fill the IMEM.
            if (capacityHit && !lastSeen_q) begin
                full_d = 1'b1;
            end
        end
    end

    // State and control registers; reset abandons any buffered words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= ADDR_BASE;
            count_q    <= '0;
            full_q     <= 1'b0;
            lastSeen_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            lastSeen_q <= lastSeen_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            occ_q      <= occ_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= encWord;
        end
    end

`ifdef ENC_CHECK_EN
    logic err_q, err_d;
    logic reqBad;

    assign reqBad = !class_legal(in_class) || !imm_fits(in_class, in_funct3, in_imm);

    // Sticky for the whole session, cleared only by the next accepted start
    always_comb begin
        err_d = err_q;
        if (startOk) begin
            err_d = 1'b0;
        end else if (push && reqBad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign imem_we    = pop;
    assign imem_addr  = addr_q;
    assign imem_wdata = pop ? fifoMem_q[rdPtr_q] : '0;
    assign busy       = inLoad;
    assign done       = (state_q == ST_DONE);
    assign full       = full_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
// Table of single-request sessions with hand-encoded RV32I words, followed by
// hand-written sequences: back-to-back program, IMEM capacity, reset during a
// session, and start handling in LOAD and DONE. ADDR_W is 3 so the capacity
// corner needs only 8 writes.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int AW = 3;

`ifdef ENC_CHECK_EN
    localparam logic CHECKS_ON = 1'b1;
`else
    localparam logic CHECKS_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] expWord;
        logic        bad;
    } vec_t;

    logic          clock;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_class;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   count;
    logic          err;

    int checks   = 0;
    int failures = 0;

    vec_t          vecs [16];
    logic [31:0]   wrData [$];
    logic [AW-1:0] wrAddr [$];

    instr_encoder_loader #(
        .ADDR_W     (AW),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (0)
    ) dut (
        .clk        (clock),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .count      (count),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log every IMEM write; the write commits on the following rising edge
    always @(negedge clock) begin
        if (rst_n && imem_we) begin
            wrData.push_back(imem_wdata);
            wrAddr.push_back(imem_addr);
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input logic [3:0] c, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm, input logic [31:0] w,
                                   input logic bad);
        vec_t v;
        v.cls = c; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.expWord = w; v.bad = bad;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one request at a falling edge and hold it until it is accepted
    task automatic applyStimulus(input vec_t v, input logic last);
        int guard;
        @(negedge clock);
        in_class  = v.cls;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
        in_last   = last;
        in_valid  = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulseStart(input logic clearLog);
        if (clearLog) begin
            wrData.delete();
            wrAddr.delete();
        end
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int guard;
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    initial begin
        vecs[0]  = mkVec(4'd0,  5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,        32'h003100B3, 1'b0);
        vecs[1]  = mkVec(4'd1,  5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0);
        vecs[2]  = mkVec(4'd2,  5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'd8,        32'h00812283, 1'b0);
        vecs[3]  = mkVec(4'd3,  5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'd12,       32'h00512623, 1'b0);
        vecs[4]  = mkVec(4'd4,  5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8,        32'h00208463, 1'b0);
        vecs[5]  = mkVec(4'd5,  5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16,       32'h010000EF, 1'b0);
        vecs[6]  = mkVec(4'd7,  5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123450B7, 1'b0);
        vecs[7]  = mkVec(4'd8,  5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 32'hFFFFF117, 1'b0);
        vecs[8]  = mkVec(4'd6,  5'd1, 5'd5, 5'd0, 3'd7, 7'h00, 32'd4,        32'h004280E7, 1'b0);
        vecs[9]  = mkVec(4'd1,  5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7,        32'h40725193, 1'b0);
        vecs[10] = mkVec(4'd1,  5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF08093, 1'b0);
        vecs[11] = mkVec(4'd3,  5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFFFFC, 32'hFE512E23, 1'b0);
        vecs[12] = mkVec(4'd5,  5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFF8, 32'hFF9FF06F, 1'b0);
        vecs[13] = mkVec(4'd12, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd5,        32'h00000013, 1'b1);
        vecs[14] = mkVec(4'd4,  5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h00208163, 1'b1);
        vecs[15] = mkVec(4'd1,  5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1);

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("rst_imem_we",  32'(imem_we),    32'd0);
        checkOutput("rst_in_ready", 32'(in_ready),   32'd0);
        checkOutput("rst_busy",     32'(busy),       32'd0);
        checkOutput("rst_done",     32'(done),       32'd0);
        checkOutput("rst_full",     32'(full),       32'd0);
        checkOutput("rst_count",    32'(count),      32'd0);
        checkOutput("rst_err",      32'(err),        32'd0);
        checkOutput("rst_wdata",    imem_wdata,      32'd0);
        checkOutput("rst_addr",     32'(imem_addr),  32'd0);
        rst_n = 1'b1;
        @(negedge clock);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_busy",     32'(busy),     32'd0);

        // One-request sessions from the table
        for (int i = 0; i < 16; i++) begin
            pulseStart(1'b1);
            checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            applyStimulus(vecs[i], 1'b1);
            waitDone($sformatf("v%0d_done", i));
            checkOutput($sformatf("v%0d_nwrites", i), 32'(wrData.size()), 32'd1);
            if (wrData.size() > 0) begin
                checkOutput($sformatf("v%0d_wdata", i), wrData[0], vecs[i].expWord);
                checkOutput($sformatf("v%0d_addr", i), 32'(wrAddr[0]), 32'd0);
            end
            checkOutput($sformatf("v%0d_count", i), 32'(count), 32'd1);
            checkOutput($sformatf("v%0d_full", i), 32'(full), 32'd0);
            checkOutput($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].bad & CHECKS_ON));
        end

        // Back-to-back program at consecutive addresses; start also clears err
        pulseStart(1'b1);
        checkOutput("prog_err_cleared", 32'(err), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(vecs[i], (i == 6));
        end
        waitDone("prog_done");
        checkOutput("prog_nwrites", 32'(wrData.size()), 32'd6);
        for (int i = 0; i < 6 && i < wrData.size(); i++) begin
            checkOutput($sformatf("prog_wdata%0d", i), wrData[i], vecs[i+1].expWord);
            checkOutput($sformatf("prog_addr%0d", i), 32'(wrAddr[i]), 32'(i));
        end
        checkOutput("prog_count", 32'(count), 32'd6);
        checkOutput("prog_full",  32'(full),  32'd0);

        // IMEM capacity with in_valid held and no in_last
        begin
            int accepted;
            int guard;
            accepted = 0;
            guard = 0;
            pulseStart(1'b1);
            in_class = vecs[1].cls; in_rd = vecs[1].rd; in_rs1 = vecs[1].rs1;
            in_rs2 = vecs[1].rs2; in_funct3 = vecs[1].f3; in_funct7 = vecs[1].f7;
            in_imm = vecs[1].imm; in_last = 1'b0; in_valid = 1'b1;
            while (!done && guard < 100) begin
                if (in_ready) accepted++;
                @(negedge clock);
                guard++;
            end
            checkOutput("cap_done",     32'(done),      32'd1);
            checkOutput("cap_in_ready", 32'(in_ready),  32'd0);
            in_valid = 1'b0;
            checkOutput("cap_accepted", 32'(accepted),  32'd8);
            checkOutput("cap_full",     32'(full),      32'd1);
            checkOutput("cap_count",    32'(count),     32'd8);
            checkOutput("cap_addr_wrap", 32'(imem_addr), 32'd0);
            repeat (3) @(negedge clock);
            checkOutput("cap_nwrites",  32'(wrData.size()), 32'd8);
            for (int i = 0; i < 8 && i < wrAddr.size(); i++) begin
                checkOutput($sformatf("cap_addr%0d", i), 32'(wrAddr[i]), 32'(i));
            end
        end

        // Asynchronous reset while a word is still buffered
        pulseStart(1'b1);
        applyStimulus(vecs[0], 1'b0);
        checkOutput("rstmid_we_before", 32'(imem_we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        wrData.delete();
        wrAddr.delete();
        checkOutput("rstmid_imem_we",  32'(imem_we),   32'd0);
        checkOutput("rstmid_wdata",    imem_wdata,     32'd0);
        checkOutput("rstmid_busy",     32'(busy),      32'd0);
        checkOutput("rstmid_in_ready", 32'(in_ready),  32'd0);
        checkOutput("rstmid_count",    32'(count),     32'd0);
        checkOutput("rstmid_addr",     32'(imem_addr), 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("rstmid_nwrites", 32'(wrData.size()), 32'd0);
        checkOutput("rstmid_idle",    32'(busy),          32'd0);

        // start in LOAD is ignored; start in DONE restarts at BASE_ADDR
        pulseStart(1'b1);
        applyStimulus(vecs[1], 1'b0);
        repeat (2) @(negedge clock);
        checkOutput("s6_count1", 32'(count), 32'd1);
        pulseStart(1'b0);
        checkOutput("s6_busy_kept",  32'(busy),      32'd1);
        checkOutput("s6_count_kept", 32'(count),     32'd1);
        checkOutput("s6_addr_kept",  32'(imem_addr), 32'd1);
        applyStimulus(vecs[2], 1'b1);
        waitDone("s6_done");
        checkOutput("s6_nwrites", 32'(wrData.size()), 32'd2);
        if (wrData.size() == 2) begin
            checkOutput("s6_addr1",  32'(wrAddr[1]), 32'd1);
            checkOutput("s6_wdata1", wrData[1],      vecs[2].expWord);
        end
        checkOutput("s6_count2", 32'(count), 32'd2);
        pulseStart(1'b1);
        checkOutput("s6_restart_done",  32'(done),      32'd0);
        checkOutput("s6_restart_count", 32'(count),     32'd0);
        checkOutput("s6_restart_addr",  32'(imem_addr), 32'd0);
        checkOutput("s6_restart_busy",  32'(busy),      32'd1);
        applyStimulus(vecs[0], 1'b1);
        waitDone("s6_restart_finish");
        checkOutput("s6_restart_nwrites", 32'(wrData.size()), 32'd1);
        if (wrData.size() > 0) begin
            checkOutput("s6_restart_waddr", 32'(wrAddr[0]), 32'd0);
            checkOutput("s6_restart_wdata", wrData[0],      vecs[0].expWord);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
